// File: rtl/mul_cell_arbiter.sv
// Two-requester round-robin front end for a shared 16x16 partial-product multiplier cell.
// One operation in flight at a time; the low 32 bits of src1*src2 are returned with requester id and tag.
module mul_cell_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_src1,
  input  logic [31:0]      req0_src2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_src1,
  input  logic [31:0]      req1_src2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      mc_src1,
  output logic [31:0]      mc_src2,
  output logic             mc_en,
  input  logic [31:0]      mc_p1,
  input  logic [31:0]      mc_p2,
  input  logic [31:0]      mc_p3,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_COMPUTE,
    S_RESP
  } state_t;

  state_t           r_state;
  logic             r_last;
  logic [31:0]      r_src1;
  logic [31:0]      r_src2;
  logic [TAG_W-1:0] r_tag;
  logic             r_mc_en;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_id;
  logic [TAG_W-1:0] r_rsp_tag;

  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [31:0]      w_result;

  // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
  assign w_idle     = (r_state == S_IDLE);
  assign w_grant1   = req1_valid & (~req0_valid | ~r_last);
  assign w_grant0   = req0_valid & ~w_grant1;
  assign req0_ready = w_idle & ~reset & w_grant0;
  assign req1_ready = w_idle & ~reset & w_grant1;
  assign w_accept   = req0_ready | req1_ready;

  // The hi*hi product never reaches the low 32 bits; the cross sum only contributes its low half.
  assign w_result = mc_p1 + ((mc_p2 + mc_p3) << 16);

  assign mc_src1   = r_src1;
  assign mc_src2   = r_src2;
  assign mc_en     = r_mc_en;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_tag   = r_rsp_tag;
  assign busy      = ~w_idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_src1      <= '0;
      r_src2      <= '0;
      r_tag       <= '0;
      r_mc_en     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= 1'b0;
      r_rsp_tag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_src1  <= w_grant1 ? req1_src1 : req0_src1;
            r_src2  <= w_grant1 ? req1_src2 : req0_src2;
            r_tag   <= w_grant1 ? req1_tag  : req0_tag;
            r_last  <= w_grant1;
            r_mc_en <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_mc_en <= 1'b0;
          r_state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          r_rsp_data  <= w_result;
          r_rsp_id    <= r_last;
          r_rsp_tag   <= r_tag;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_cell_arbiter.sv
// Bench for mul_cell_arbiter: transaction-level timing model plus a registered multiplier-cell model,
// directed corner scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_mul_cell_arbiter;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0_valid = 1'b0;
  logic             req0_ready;
  logic [31:0]      req0_src1 = '0;
  logic [31:0]      req0_src2 = '0;
  logic [TAG_W-1:0] req0_tag = '0;
  logic             req1_valid = 1'b0;
  logic             req1_ready;
  logic [31:0]      req1_src1 = '0;
  logic [31:0]      req1_src2 = '0;
  logic [TAG_W-1:0] req1_tag = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [31:0]      rsp_data;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      mc_src1;
  logic [31:0]      mc_src2;
  logic             mc_en;
  logic [31:0]      mc_p1 = '0;
  logic [31:0]      mc_p2 = '0;
  logic [31:0]      mc_p3 = '0;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  mul_cell_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1),
    .req0_src2(req0_src2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1),
    .req1_src2(req1_src2), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .mc_src1(mc_src1), .mc_src2(mc_src2), .mc_en(mc_en),
    .mc_p1(mc_p1), .mc_p2(mc_p2), .mc_p3(mc_p3),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier cell: products registered one cycle after mc_en.
  always @(posedge clk) begin
    if (mc_en) begin
      mc_p1 <= 32'(mc_src1[15:0])  * 32'(mc_src2[15:0]);
      mc_p2 <= 32'(mc_src1[15:0])  * 32'(mc_src2[31:16]);
      mc_p3 <= 32'(mc_src1[31:16]) * 32'(mc_src2[15:0]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction model: an op accepted in cycle A shows mc_en at A+1, result at A+3,
  // and stays until the handshake; the result is simply the low 32 bits of the product.
  int               cyc = 0;
  bit               m_known = 0;
  bit               m_inflight = 0;
  int               m_acc = 0;
  logic             m_last = 1'b1;
  logic [31:0]      m_src1 = '0;
  logic [31:0]      m_src2 = '0;
  logic [TAG_W-1:0] m_tag = '0;
  logic [31:0]      m_rdata = '0;
  logic             m_rid = 1'b0;
  logic [TAG_W-1:0] m_rtag = '0;
  logic             e_g1, e_r0, e_r1, e_rv;
  logic [63:0]      m_prod;

  always @(negedge clk) begin
    cyc++;
    e_g1 = req1_valid && (!req0_valid || m_last == 1'b0);
    e_r0 = !reset && m_known && !m_inflight && req0_valid && !e_g1;
    e_r1 = !reset && m_known && !m_inflight && e_g1;
    e_rv = m_inflight && (cyc >= m_acc + 3);
    if (m_known) begin
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("busy", busy, m_inflight);
      chk("mc_en", mc_en, m_inflight && (cyc == m_acc + 1));
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_data", rsp_data, m_rdata);
      chk("rsp_id", rsp_id, m_rid);
      chk("rsp_tag", rsp_tag, m_rtag);
      chk("mc_src1", mc_src1, m_src1);
      chk("mc_src2", mc_src2, m_src2);
    end
    if (reset) begin
      m_known = 1; m_inflight = 0; m_last = 1'b1;
      m_src1 = '0; m_src2 = '0; m_tag = '0;
      m_rdata = '0; m_rid = 1'b0; m_rtag = '0;
    end else if (m_known) begin
      if (!m_inflight) begin
        if (e_r0 || e_r1) begin
          m_inflight = 1; m_acc = cyc; m_last = e_r1;
          m_src1 = e_r1 ? req1_src1 : req0_src1;
          m_src2 = e_r1 ? req1_src2 : req0_src2;
          m_tag  = e_r1 ? req1_tag  : req0_tag;
        end
      end else begin
        if (cyc == m_acc + 2) begin
          m_prod  = 64'(m_src1) * 64'(m_src2);
          m_rdata = m_prod[31:0];
          m_rid   = m_last;
          m_rtag  = m_tag;
        end
        if (e_rv && rsp_ready) m_inflight = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] lit_prod;

  initial begin
    // Reset with req0 already valid: no ready during reset, reset values afterwards.
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_src1 = 32'h0001_0002; req0_src2 = 32'h0003_0004; req0_tag = 4'd5;
    step(); step();
    @(negedge clk);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_mc_en", mc_en, 0);
    chk("rst_mc_src1", mc_src1, 0);
    step(); reset = 1'b0;
    @(negedge clk); chk("t1_ready", req0_ready, 1);
    step(); req0_valid = 1'b0;
    @(negedge clk); chk("t1_mc_en_T1", mc_en, 1); chk("t1_mc_src1", mc_src1, 32'h0001_0002);
    step();
    @(negedge clk); chk("t1_mc_en_T2", mc_en, 0); chk("t1_valid_T2", rsp_valid, 0);
    step();
    @(negedge clk);
    chk("t1_valid_T3", rsp_valid, 1); chk("t1_data", rsp_data, 32'h000A_0008);
    chk("t1_id", rsp_id, 0); chk("t1_tag", rsp_tag, 5);
    step();
    @(negedge clk); chk("t1_idle", busy, 0);

    // All-ones operands exercise both carry wraps.
    step(); req0_valid = 1'b1; req0_src1 = 32'hFFFF_FFFF; req0_src2 = 32'hFFFF_FFFF; req0_tag = 4'd3;
    @(negedge clk); chk("t2_ready", req0_ready, 1);
    step(); req0_valid = 1'b0;
    step(); step();
    @(negedge clk); chk("t2_valid", rsp_valid, 1); chk("t2_data", rsp_data, 32'h0000_0001);
    step();

    // Both requesters valid from reset: strict alternation, one op every 4 cycles.
    reset = 1'b1;
    req0_valid = 1'b1; req0_src1 = 32'd7; req0_src2 = 32'd9; req0_tag = 4'd1;
    req1_valid = 1'b1; req1_src1 = 32'h1234_5678; req1_src2 = 32'h9ABC_DEF0; req1_tag = 4'd2;
    step(); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_grant0", req0_ready, (k % 2) == 0);
      chk("t3_grant1", req1_ready, (k % 2) == 1);
      step(); step();
      @(negedge clk); chk("t3_valid_T2", rsp_valid, 0);
      step();
      @(negedge clk); chk("t3_valid_T3", rsp_valid, 1); chk("t3_id", rsp_id, k % 2);
      step();
    end

    // Fifth grant goes to req0; stall the response for 5 cycles.
    @(negedge clk); chk("t4_grant0", req0_ready, 1);
    step(); rsp_ready = 1'b0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", rsp_valid, 1); chk("t4_hold_data", rsp_data, 32'd63);
      chk("t4_hold_tag", rsp_tag, 1);
      chk("t4_hold_r0", req0_ready, 0); chk("t4_hold_r1", req1_ready, 0);
      if (i < 4) step();
    end
    step(); rsp_ready = 1'b1;
    @(negedge clk); chk("t4_hs_valid", rsp_valid, 1); chk("t4_hs_r1", req1_ready, 0);
    step();
    @(negedge clk); chk("t4_next_r1", req1_ready, 1); chk("t4_next_r0", req0_ready, 0);
    step(); req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step();
    @(negedge clk);
    lit_prod = 64'h1234_5678 * 64'h9ABC_DEF0;
    chk("t4_r1_data", rsp_data, {32'h0, lit_prod[31:0]});
    step();

    // Reset during COMPUTE abandons the op; the still-valid requester is re-granted.
    step(); req0_valid = 1'b1; req0_src1 = 32'h8000_0003; req0_src2 = 32'h0001_FFFF; req0_tag = 4'd9;
    @(negedge clk); chk("t5_ready", req0_ready, 1);
    step(); step(); reset = 1'b1;
    step(); reset = 1'b0;
    @(negedge clk);
    chk("t5_valid", rsp_valid, 0); chk("t5_busy", busy, 0);
    chk("t5_mc_en", mc_en, 0); chk("t5_regrant", req0_ready, 1);
    step(); req0_valid = 1'b0;
    step(); step();
    @(negedge clk);
    lit_prod = 64'h8000_0003 * 64'h0001_FFFF;
    chk("t5_valid_T3", rsp_valid, 1); chk("t5_tag", rsp_tag, 9);
    chk("t5_data", rsp_data, {32'h0, lit_prod[31:0]});
    step();

    // Randomized traffic; the per-cycle model does the checking.
    for (int n = 0; n < 3000; n++) begin
      step();
      reset      = ($urandom_range(0, 149) == 0);
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      rsp_ready  = ($urandom_range(0, 9) < 6);
      req0_src1  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      req0_src2  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      req1_src1  = $urandom;
      req1_src2  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      req0_tag   = TAG_W'($urandom);
      req1_tag   = TAG_W'($urandom);
    end
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
